truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Clocked exhaustive stimulus and checking engine for N-input combinational lab circuits. It replaces hand-written per-vector delay sequences with a parametrised sweep of all 2^N input combinations. For each combination it holds the vector for a programmable number of cycles, compares the DUT output against a reference-model output, and accumulates mismatches. It sits in simulation benches and on-board self-test wrappers between a start control and the DUT plus its golden model.

## Interface
- `N`, default 4: number of DUT inputs; sweep length is 2^N vectors; legal range 1..16.
- `M`, default 1: width of the DUT output and the expected output.
- `HOLD`, default 1: clock cycles each vector is held; legal range 1..255.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: request a sweep; sampled in IDLE and DONE only.
- `vec`  out  N: vector currently applied to the DUT and the reference model.
- `dut_out`  in  M: DUT response, combinational from `vec`.
- `exp_out`  in  M: reference-model response, combinational from `vec`.
- `busy`  out  1: high while sweeping.
- `done`  out  1: high in DONE; sticky until the next start or reset.
- `pass`  out  1: equals `done` AND (`mismatch_cnt` == 0).
- `mismatch_cnt`  out  N+1: number of vectors where `dut_out` != `exp_out`; cannot overflow.
- `first_fail_valid`  out  1: a mismatch has been recorded in this sweep.
- `first_fail_vec`  out  N: `vec` value at the first mismatch.

## Operation
- FSM states: IDLE, RUN, DONE. Internal registers:
  - `idx`, N bits: sweep index.
  - `hold_cnt`, 8 bits: cycles spent on the current vector.
- IDLE → RUN when `start`=1. On entry, clear `idx`, `hold_cnt`, `mismatch_cnt`, `first_fail_valid` and `first_fail_vec`.
- In RUN, when `hold_cnt` < HOLD-1: increment `hold_cnt`.
- In RUN, when `hold_cnt` == HOLD-1: this is the compare cycle.
  - If `dut_out` != `exp_out`, increment `mismatch_cnt`.
  - If that is the first mismatch of the sweep, latch `first_fail_vec`=`vec` and set `first_fail_valid`.
  - If `idx` == 2^N-1, go to DONE.
  - Otherwise increment `idx` and clear `hold_cnt`.
- DONE → RUN on `start`=1, performing the same clear as IDLE → RUN. `start` in RUN is ignored.
- Results (`mismatch_cnt`, `first_fail_*`) stay stable in DONE until restart or reset.
- `vec` is binary `idx` (without the macro in Configuration).
- Compare is bitwise across all M bits. Any differing bit counts the vector once.

## Timing
- Reset values:
  - state=IDLE, `vec`=0, `busy`=0, `done`=0, `pass`=0.
  - `mismatch_cnt`=0, `first_fail_valid`=0, `first_fail_vec`=0.
- Reset mid-sweep: on the next edge, all outputs return to reset values and the sweep is abandoned. No partial result is retained.
- Start at edge E0: `busy`=1 and `vec`=first vector are visible after E0.
- Vector k is applied during cycles E0+k·HOLD .. E0+(k+1)·HOLD-1. It is compared at the last of those edges.
- `done` rises after edge E0 + 2^N·HOLD. `busy` falls on that same edge.
- `mismatch_cnt` updates one edge after the compare cycle's inputs are sampled. The registered value is therefore lagged by at most one vector.
- `start` held high continuously: the first sweep begins. After DONE, a new sweep begins on the very next edge, with `done` visible for exactly one cycle.
- With HOLD=1 the sweep takes exactly 2^N cycles.

## Configuration
- `SWEEP_GRAY_EN` defined: `vec` = `idx` ^ (`idx` >> 1), a Gray-code order with one input toggling per step. This is used to observe hazard-free transitions. `first_fail_vec` captures the Gray value actually applied.
- `SWEEP_GRAY_EN` undefined: `vec` = `idx`, ascending binary 0..2^N-1. No Gray logic is present.
- Sweep length, timing and counts are identical in both builds.

## Test plan
- Pass sweep, N=4, HOLD=1, `exp_out` model identical to the DUT, start pulse:
  - `vec` steps 0..15, one per cycle.
  - `done`=1 exactly 16 cycles after start; `pass`=1; `mismatch_cnt`=0; `first_fail_valid`=0.
- Faulty model, N=4, HOLD=1, `exp_out` inverted at vectors 5 and 11:
  - `mismatch_cnt`=2, `first_fail_vec`=5, `first_fail_valid`=1, `pass`=0.
- Slow hold, N=4, HOLD=3:
  - `vec` changes every 3 cycles.
  - `done` rises 48 cycles after start.
  - A mismatch injected only during the first 2 cycles of vector 9 (glitch) is not counted.
- Reset mid-sweep, rst=1 for one cycle while `vec`=7:
  - Next cycle: `vec`=0, `busy`=0, `done`=0, `mismatch_cnt`=0.
  - A subsequent start sweeps from 0.
- Start handling:
  - `start` pulses during RUN leave the sequence and the 16-cycle length unchanged.
  - A `start` in DONE clears `mismatch_cnt` and `done` and restarts at `vec`=0.
- `SWEEP_GRAY_EN` build, N=4:
  - `vec` sequence is 0,1,3,2,6,7,5,4,…, ending at 8.
  - Every step changes exactly one bit.
  - A fault at binary index 3 reports `first_fail_vec`=2.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks all 2^N input vectors, holds each for HOLD cycles, counts dut/exp mismatches.
// Latency: vec valid the edge after start; done rises 2^N*HOLD edges after start. No backpressure; start ignored while busy.
// Build option: define SWEEP_GRAY_EN to apply vectors in Gray-code order instead of ascending binary.
module truth_table_sweeper #(
    parameter int N    = 4,
    parameter int M    = 1,
    parameter int HOLD = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] vec,
    input  logic [M-1:0] dut_out,
    input  logic [M-1:0] exp_out,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   mismatch_cnt,
    output logic         first_fail_valid,
    output logic [N-1:0] first_fail_vec
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] idx;
    logic [7:0]   hold_cnt;
    logic         launch;
    logic         compare;
    logic         last_vec;
    logic         mismatch;

    assign last_vec = (idx == {N{1'b1}});
    // Any differing bit counts the vector once.
    assign mismatch = (dut_out != exp_out);

`ifdef SWEEP_GRAY_EN
    assign vec = idx ^ (idx >> 1);
`else
    assign vec = idx;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        compare   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    launch    = 1'b1;
                end
            end
            RUN: begin
                if (hold_cnt == HOLD_LAST) begin
                    compare = 1'b1;
                    if (last_vec) begin
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || launch) begin
            idx              <= '0;
            hold_cnt         <= '0;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (state == RUN) begin
            if (compare) begin
                if (mismatch) begin
                    // Width N+1 holds up to 2^N, so this cannot wrap.
                    mismatch_cnt <= mismatch_cnt + (N+1)'(1);
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_vec   <= vec;
                    end
                end
                if (!last_vec) begin
                    idx      <= idx + N'(1);
                    hold_cnt <= '0;
                end
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (mismatch_cnt == '0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench for truth_table_sweeper: two instances (HOLD=1, HOLD=3) checked cycle by cycle
// against a sweep model built from vector index arithmetic and per-cycle injected errors.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s    [2];
    logic [3:0] vec_s      [2];
    logic [1:0] dut_out_s  [2];
    logic [1:0] exp_out_s  [2];
    logic [1:0] err_s      [2];
    logic       busy_s     [2];
    logic       done_s     [2];
    logic       pass_s     [2];
    logic [4:0] cnt_s      [2];
    logic       ffv_s      [2];
    logic [3:0] ffvec_s    [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [1:0] golden(input logic [3:0] v);
        return {v[3] ^ v[0], ^v};
    endfunction

    function automatic logic [3:0] vec_of(input int k);
`ifdef SWEEP_GRAY_EN
        return 4'(k ^ (k >> 1));
`else
        return 4'(k);
`endif
    endfunction

    assign dut_out_s[0] = golden(vec_s[0]);
    assign exp_out_s[0] = golden(vec_s[0]) ^ err_s[0];
    assign dut_out_s[1] = golden(vec_s[1]);
    assign exp_out_s[1] = golden(vec_s[1]) ^ err_s[1];

    truth_table_sweeper #(.N(4), .M(2), .HOLD(1)) u_dut_h1 (
        .clk              (clk),
        .rst              (rst),
        .start            (start_s[0]),
        .vec              (vec_s[0]),
        .dut_out          (dut_out_s[0]),
        .exp_out          (exp_out_s[0]),
        .busy             (busy_s[0]),
        .done             (done_s[0]),
        .pass             (pass_s[0]),
        .mismatch_cnt     (cnt_s[0]),
        .first_fail_valid (ffv_s[0]),
        .first_fail_vec   (ffvec_s[0])
    );

    truth_table_sweeper #(.N(4), .M(2), .HOLD(3)) u_dut_h3 (
        .clk              (clk),
        .rst              (rst),
        .start            (start_s[1]),
        .vec              (vec_s[1]),
        .dut_out          (dut_out_s[1]),
        .exp_out          (exp_out_s[1]),
        .busy             (busy_s[1]),
        .done             (done_s[1]),
        .pass             (pass_s[1]),
        .mismatch_cnt     (cnt_s[1]),
        .first_fail_valid (ffv_s[1]),
        .first_fail_vec   (ffvec_s[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, "_vec"},  vec_s[d],   0);
        check({tag, "_busy"}, busy_s[d],  0);
        check({tag, "_done"}, done_s[d],  0);
        check({tag, "_pass"}, pass_s[d],  0);
        check({tag, "_cnt"},  cnt_s[d],   0);
        check({tag, "_ffv"},  ffv_s[d],   0);
        check({tag, "_ffvec"}, ffvec_s[d], 0);
    endtask

    task automatic wait_done(input int d);
        int budget;
        budget = 200;
        while (!done_s[d] && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("wait_done_timeout", done_s[d], 1);
    endtask

    // start_mode: 0 = single pulse, 1 = random start pulses during RUN, 2 = start held high throughout.
    task automatic sweep(input int d, input int hold, input logic [15:0] faults,
                         input int glitch_k, input int start_mode);
        int         cnt;
        int         first;
        int         k;
        logic [1:0] e;
        cnt   = 0;
        first = -1;
        start_s[d] = 1'b1;
        err_s[d]   = '0;
        @(negedge clk);
        if (start_mode != 2) start_s[d] = 1'b0;
        for (int c = 0; c < 16 * hold; c++) begin
            k = c / hold;
            check("run_vec",  vec_s[d],  vec_of(k));
            check("run_busy", busy_s[d], 1);
            check("run_done", done_s[d], 0);
            check("run_cnt",  cnt_s[d],  cnt);
            check("run_ffv",  ffv_s[d],  first >= 0);
            e = '0;
            if (faults[k]) e = 2'($urandom_range(1, 3));
            else if (k == glitch_k && (c % hold) < 2) e = 2'($urandom_range(1, 3));
            err_s[d] = e;
            if (start_mode == 1) start_s[d] = 1'($urandom_range(0, 1));
            if ((c % hold) == hold - 1 && e != '0) begin
                cnt++;
                if (first < 0) first = int'(vec_of(k));
            end
            @(negedge clk);
        end
        if (start_mode == 1) start_s[d] = 1'b0;
        err_s[d] = '0;
        check("end_done",  done_s[d],  1);
        check("end_busy",  busy_s[d],  0);
        check("end_pass",  pass_s[d],  cnt == 0);
        check("end_cnt",   cnt_s[d],   cnt);
        check("end_ffv",   ffv_s[d],   first >= 0);
        check("end_ffvec", ffvec_s[d], first < 0 ? 0 : first);
        if (start_mode == 2) begin
            @(negedge clk);
            check("held_done", done_s[d], 0);
            check("held_busy", busy_s[d], 1);
            check("held_vec",  vec_s[d],  vec_of(0));
            check("held_cnt",  cnt_s[d],  0);
            start_s[d] = 1'b0;
            wait_done(d);
        end else begin
            repeat (3) @(negedge clk);
            check("sticky_done", done_s[d], 1);
            check("sticky_cnt",  cnt_s[d],  cnt);
            check("sticky_ffvec", ffvec_s[d], first < 0 ? 0 : first);
        end
    endtask

    task automatic reset_mid_sweep();
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int c = 0; c < 7; c++) begin
            err_s[0] = (c == 2) ? 2'b01 : 2'b00;
            @(negedge clk);
        end
        err_s[0] = '0;
        check("pre_rst_vec", vec_s[0], vec_of(7));
        check("pre_rst_cnt", cnt_s[0], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle(0, "mid_rst");
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0;
            err_s[d]   = '0;
        end
        repeat (2) @(negedge clk);
        check_idle(0, "rst_h1");
        check_idle(1, "rst_h3");
        rst = 1'b0;
        @(negedge clk);

        sweep(0, 1, 16'h0000, -1, 0);
        sweep(0, 1, 16'h0820, -1, 0);
        sweep(1, 3, 16'h0000, 9, 0);
        sweep(1, 3, 16'($urandom), -1, 1);
        sweep(0, 1, 16'($urandom), -1, 1);
        sweep(0, 1, 16'h0008, -1, 0);
        reset_mid_sweep();
        sweep(0, 1, 16'($urandom), -1, 0);
        sweep(0, 1, 16'($urandom), -1, 2);
        for (int i = 0; i < 4; i++) begin
            sweep(0, 1, 16'($urandom), -1, int'($urandom_range(0, 1)));
            sweep(1, 3, 16'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
        end
        sweep(0, 1, 16'hFFFF, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
